// File: rtl/serial_arith_unit.sv
// serial_arith_unit: bit-serial PASS/LDN/SUB/CLR stage feeding the accumulator write unit.
// Optional overflow flag is built only when SERIAL_ARITH_OVF_EN is defined; otherwise w_OVF is tied low.
module serial_arith_unit #(
    parameter int INSTR_BITS   = 20,
    parameter int FLYBACK_TIME = 4
) (
    input  logic                          w_DPG,
    input  logic                          w_RST,
    input  logic                          w_A_DATA_OUT,
    input  logic                          w_MS_DATA_OUT,
    input  logic [1:0]                    b_OP,
    output logic                          w_A_DATA_IN,
    output logic                          w_A_DATA_VALID,
    output logic [$clog2(INSTR_BITS)-1:0] b_BIT_IDX,
    output logic                          w_BEAT_START,
    output logic                          w_A_NEG,
    output logic                          w_OVF
);
    localparam int BEAT = INSTR_BITS + FLYBACK_TIME;
    localparam int CW   = $clog2(BEAT);
    localparam int IW   = $clog2(INSTR_BITS);
    localparam logic [1:0] OP_PASS = 2'b00, OP_LDN = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [1:0] op_q, op;
    logic borrow, b_in, a_eff, r, b_next, data_digit, last_digit;

    // State register: a reset restarts the beat, so the FSM comes back in RUN at counter 0
    always_ff @(posedge w_DPG) begin
        if (w_RST) state <= RUN;
        else       state <= next_state;
    end

    // Next state: enter RUN as the counter wraps to 0, drop to IDLE once the last data digit is taken
    always_comb begin
        next_state = cnt == CW'(BEAT - 1)       ? RUN  :
                     cnt == CW'(INSTR_BITS - 1) ? IDLE : state;
    end

    // FSM outputs: data-digit qualifier, final-digit strobe and combinational beat start
    always_comb begin
        data_digit   = state == RUN;
        last_digit   = data_digit && cnt == CW'(INSTR_BITS - 1);
        w_BEAT_START = cnt == '0;
    end

    // Per-digit serial subtractor; digit 0 uses the live op and a cleared borrow
    always_comb begin
        op     = cnt == '0 ? b_OP : op_q;
        b_in   = cnt != '0 && borrow;
        a_eff  = w_A_DATA_OUT & (op != OP_LDN);
        b_next = (~a_eff & w_MS_DATA_OUT) | (~(a_eff ^ w_MS_DATA_OUT) & b_in);
        r      = op == OP_PASS ? w_A_DATA_OUT :
                 op == OP_CLR  ? 1'b0 : a_eff ^ w_MS_DATA_OUT ^ b_in;
    end

    // Beat counter, op latch at digit 0 and borrow chain
    always_ff @(posedge w_DPG) begin
        if (w_RST) begin
            cnt    <= '0;
            borrow <= 1'b0;
            op_q   <= OP_PASS;
        end else begin
            cnt <= cnt == CW'(BEAT - 1) ? '0 : cnt + 1'b1;
            if (cnt == '0) op_q <= b_OP;
            if (data_digit) borrow <= b_next;
        end
    end

    // Registered result stream; sign captured with the final data digit
    always_ff @(posedge w_DPG) begin
        if (w_RST) begin
            w_A_DATA_IN    <= 1'b0;
            w_A_DATA_VALID <= 1'b0;
            b_BIT_IDX      <= '0;
            w_A_NEG        <= 1'b0;
        end else if (data_digit) begin
            w_A_DATA_IN    <= r;
            w_A_DATA_VALID <= 1'b1;
            b_BIT_IDX      <= IW'(cnt);
            if (last_digit) w_A_NEG <= r;
        end else begin
            w_A_DATA_IN    <= 1'b0;
            w_A_DATA_VALID <= 1'b0;
        end
    end

`ifdef SERIAL_ARITH_OVF_EN
    logic ovf_next;

    // Overflow from the sign digits seen at the final data digit
    always_comb begin
        ovf_next = op == OP_SUB ? (w_A_DATA_OUT != w_MS_DATA_OUT) && (r != w_A_DATA_OUT) :
                   op == OP_LDN ? w_MS_DATA_OUT & r : 1'b0;
    end

    // Overflow flag updates alongside the sign
    always_ff @(posedge w_DPG) begin
        if (w_RST)           w_OVF <= 1'b0;
        else if (last_digit) w_OVF <= ovf_next;
    end
`else
    assign w_OVF = 1'b0;
`endif
endmodule
